// File: rtl/fastram_sdram_bridge.sv
// Bridges the CPU fast-RAM port onto SDRAM channel 0: one request per strobed access, CPU stalled until done.
// Optional one-entry read cache enabled by defining FASTRAM_READ_CACHE_EN.
module fastram_sdram_bridge #(
    parameter int CPU_AW  = 23,
    parameter int SD_AW   = 25,
    parameter int ACK_WIN = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              fast_clk,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait,
    output logic [SD_AW-1:0]  sd_addr,
    output logic              sd_wr,
    output logic              sd_rd,
    output logic [7:0]        sd_din,
    input  logic [7:0]        sd_dout,
    input  logic              sd_busy,
    output logic              err_timeout
);

    localparam int                ACK_CW   = $clog2(ACK_WIN + 1);
    localparam logic [ACK_CW-1:0] ACK_LAST = ACK_CW'(ACK_WIN - 1);
    localparam logic [9:0]        TO_MAX   = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [CPU_AW-1:0] addr_r;
    logic [7:0]        din_r;
    logic              we_r;
    logic [ACK_CW-1:0] ack_cnt_r;
    logic [9:0]        to_cnt_r;

    logic              cpu_wait_r;
    logic              sd_wr_r;
    logic              sd_rd_r;
    logic              err_timeout_r;
    logic [7:0]        cpu_dout_r;

    logic              strobe_s;
    logic              hit_s;
    logic [7:0]        hit_data_s;
    logic              accept_s;
    logic              ack_last_s;
    logic              done_ok_s;
    logic              capture_s;
    logic              abort_s;

    logic              cpu_wait_nxt_s;
    logic              sd_wr_nxt_s;
    logic              sd_rd_nxt_s;
    logic              err_nxt_s;

    assign strobe_s   = fast_clk & cpu_ce;
    assign accept_s   = (state_r == IDLE) & strobe_s & ~hit_s;
    assign ack_last_s = (ack_cnt_r == ACK_LAST);
    // A quiet controller for the whole ack window means the access already finished.
    assign done_ok_s  = ~sd_busy & (((state_r == WAIT_ACK) & ack_last_s) | (state_r == WAIT_DONE));
    assign capture_s  = done_ok_s & ~we_r;
    assign abort_s    = (state_r == WAIT_DONE) & sd_busy & (to_cnt_r == TO_MAX);

`ifdef FASTRAM_READ_CACHE_EN
    logic [CPU_AW-1:0] tag_r;
    logic [7:0]        cache_data_r;
    logic              cache_valid_r;
    logic              tag_match_s;

    assign tag_match_s = cache_valid_r & (tag_r == cpu_addr);
    assign hit_s       = (state_r == IDLE) & strobe_s & ~cpu_we & tag_match_s;
    assign hit_data_s  = cache_data_r;

    // Cache entry: filled on read capture, written through on tagged writes, dropped on timeout.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tag_r         <= {CPU_AW{1'b0}};
            cache_data_r  <= 8'h00;
            cache_valid_r <= 1'b0;
        end else if (abort_s) begin
            cache_valid_r <= 1'b0;
        end else if (capture_s) begin
            tag_r         <= addr_r;
            cache_data_r  <= sd_dout;
            cache_valid_r <= 1'b1;
        end else if (accept_s & cpu_we & tag_match_s) begin
            cache_data_r  <= cpu_din;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign hit_data_s = 8'h00;
`endif

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = ISSUE;
                else          state_nxt_s = IDLE;
            end
            ISSUE: begin
                if (!sd_busy) state_nxt_s = WAIT_ACK;
                else          state_nxt_s = ISSUE;
            end
            WAIT_ACK: begin
                if (sd_busy)         state_nxt_s = WAIT_DONE;
                else if (ack_last_s) state_nxt_s = DONE;
                else                 state_nxt_s = WAIT_ACK;
            end
            WAIT_DONE: begin
                if (!sd_busy || abort_s) state_nxt_s = DONE;
                else                     state_nxt_s = WAIT_DONE;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; every value here is registered one edge later.
    always_comb begin
        cpu_wait_nxt_s = 1'b0;
        sd_wr_nxt_s    = 1'b0;
        sd_rd_nxt_s    = 1'b0;
        err_nxt_s      = 1'b0;
        case (state_r)
            IDLE: begin
                cpu_wait_nxt_s = accept_s;
            end
            ISSUE: begin
                cpu_wait_nxt_s = 1'b1;
                if (!sd_busy) begin
                    sd_wr_nxt_s = we_r;
                    sd_rd_nxt_s = ~we_r;
                end else begin
                    sd_wr_nxt_s = 1'b0;
                    sd_rd_nxt_s = 1'b0;
                end
            end
            WAIT_ACK: begin
                cpu_wait_nxt_s = 1'b1;
            end
            WAIT_DONE: begin
                cpu_wait_nxt_s = 1'b1;
                err_nxt_s      = abort_s;
            end
            DONE: begin
                cpu_wait_nxt_s = 1'b0;
            end
            default: begin
                cpu_wait_nxt_s = 1'b0;
            end
        endcase
    end

    // Request latches, handshake counters and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_r        <= {CPU_AW{1'b0}};
            din_r         <= 8'h00;
            we_r          <= 1'b0;
            ack_cnt_r     <= {ACK_CW{1'b0}};
            to_cnt_r      <= 10'd0;
            cpu_wait_r    <= 1'b0;
            sd_wr_r       <= 1'b0;
            sd_rd_r       <= 1'b0;
            err_timeout_r <= 1'b0;
            cpu_dout_r    <= 8'h00;
        end else begin
            cpu_wait_r    <= cpu_wait_nxt_s;
            sd_wr_r       <= sd_wr_nxt_s;
            sd_rd_r       <= sd_rd_nxt_s;
            err_timeout_r <= err_nxt_s;

            if (accept_s) begin
                addr_r <= cpu_addr;
                din_r  <= cpu_din;
                we_r   <= cpu_we;
            end

            if (state_r == WAIT_ACK) begin
                ack_cnt_r <= ack_cnt_r + {{(ACK_CW-1){1'b0}}, 1'b1};
            end else begin
                ack_cnt_r <= {ACK_CW{1'b0}};
            end

            // Saturating; restarts from zero on each entry to WAIT_DONE.
            if (state_r == WAIT_DONE) begin
                if (to_cnt_r != 10'h3FF) to_cnt_r <= to_cnt_r + 10'd1;
            end else begin
                to_cnt_r <= 10'd0;
            end

            if (capture_s) begin
                cpu_dout_r <= sd_dout;
            end else if (abort_s & ~we_r) begin
                cpu_dout_r <= 8'hFF;
            end else if (hit_s) begin
                cpu_dout_r <= hit_data_s;
            end
        end
    end

    assign cpu_dout    = cpu_dout_r;
    assign cpu_wait    = cpu_wait_r;
    assign sd_wr       = sd_wr_r;
    assign sd_rd       = sd_rd_r;
    assign err_timeout = err_timeout_r;
    assign sd_addr     = SD_AW'(addr_r);
    assign sd_din      = din_r;

endmodule

// File: tb/tb_fastram_sdram_bridge.sv
// Self-checking bench for fastram_sdram_bridge: scoreboarded SDRAM requests plus per-scenario checks.
module tb_fastram_sdram_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        fast_clk;
    logic        cpu_ce;
    logic        cpu_we;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [24:0] sd_addr;
    logic        sd_wr;
    logic        sd_rd;
    logic [7:0]  sd_din;
    logic [7:0]  sd_dout;
    logic        sd_busy;
    logic        err_timeout;

    always #5 clk_sys = ~clk_sys;

    fastram_sdram_bridge dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .fast_clk   (fast_clk),
        .cpu_ce     (cpu_ce),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait   (cpu_wait),
        .sd_addr    (sd_addr),
        .sd_wr      (sd_wr),
        .sd_rd      (sd_rd),
        .sd_din     (sd_din),
        .sd_dout    (sd_dout),
        .sd_busy    (sd_busy),
        .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  din;
    } req_t;

    req_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_cycles;
    int          err_pulses;
    int          bad_pulses;
    int          addr_changes;
    int          ctl_left;
    int          ctl_hold;
    bit          ctl_en;
    bit          ctl_pending;
    logic        prev_wait;
    logic [24:0] prev_addr;

    // One clock: sample outputs 1 time unit after the edge, score requests, then advance the controller model.
    task automatic step();
        req_t exp;
        req_t got;
        @(posedge clk_sys);
        #1;
        if (cpu_wait === 1'b1) wait_cycles++;
        if (err_timeout === 1'b1) err_pulses++;
        if (cpu_wait && prev_wait && (sd_addr !== prev_addr)) addr_changes++;
        prev_wait = cpu_wait;
        prev_addr = sd_addr;
        if ((sd_wr || sd_rd) && sd_busy) bad_pulses++;
        if (ctl_pending) begin
            sd_busy     = 1'b1;
            ctl_left    = ctl_hold;
            ctl_pending = 1'b0;
        end else if (ctl_left > 0) begin
            ctl_left--;
            if (ctl_left == 0) sd_busy = 1'b0;
        end
        if (sd_wr || sd_rd) begin
            n_checks++;
            got = {sd_wr, sd_addr, sd_din};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sd_request: unexpected wr=%0b rd=%0b addr=%h, required no request", sd_wr, sd_rd, sd_addr);
            end else begin
                exp = exp_q.pop_front();
                if ((got !== exp) || (sd_rd === sd_wr)) begin
                    n_fail++;
                    $display("FAIL sd_request: got wr=%0b rd=%0b addr=%h din=%h, required wr=%0b rd=%0b addr=%h din=%h",
                             sd_wr, sd_rd, sd_addr, sd_din, exp.wr, ~exp.wr, exp.addr, exp.din);
                end
            end
            ctl_pending = ctl_en;
        end
    endtask

    // One CPU access; an optional stray strobe is presented glitch_at cycles into the stall.
    task automatic cpu_access(input bit we, input logic [22:0] addr, input logic [7:0] din,
                              input bit exp_req, input int max_steps, input int glitch_at);
        int n;
        n = 0;
        wait_cycles = 0;
        err_pulses  = 0;
        if (exp_req) exp_q.push_back({we, 2'b00, addr, din});
        fast_clk = 1'b1; cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        step();
        fast_clk = 1'b0; cpu_ce = 1'b0;
        while (cpu_wait && (n < max_steps)) begin
            if (n == glitch_at) begin
                fast_clk = 1'b1; cpu_ce = 1'b1; cpu_we = ~we;
                cpu_addr = addr ^ 23'h7FFFFF; cpu_din = ~din;
            end else begin
                fast_clk = 1'b0; cpu_ce = 1'b0;
            end
            step();
            n++;
        end
        fast_clk = 1'b0; cpu_ce = 1'b0;
        n_checks++;
        if (cpu_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL access_bound: cpu_wait=%b after %0d cycles, required 0", cpu_wait, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        n_checks++;
        if (cpu_dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_dout: got %h, required 00", cpu_dout);
        end
        n_checks++;
        if ({cpu_wait, sd_wr, sd_rd, sd_addr, sd_din, err_timeout} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wait=%b wr=%b rd=%b addr=%h din=%h err=%b, required all 0",
                     cpu_wait, sd_wr, sd_rd, sd_addr, sd_din, err_timeout);
        end
        reset_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_write();
        ctl_hold = 6;
        sd_dout  = 8'h99;
        cpu_access(1'b1, 23'h012345, 8'hA5, 1'b1, 100, -1);
        n_checks++;
        if (wait_cycles != 10) begin
            n_fail++; $display("FAIL write_latency: cpu_wait high %0d cycles, required 10", wait_cycles);
        end
        n_checks++;
        if (cpu_dout !== 8'h00) begin
            n_fail++; $display("FAIL write_dout: got %h, required 00", cpu_dout);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL write_missing: %0d requests not seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_read();
        ctl_hold = 6;
        sd_dout  = 8'h3C;
        cpu_access(1'b0, 23'h012345, 8'h00, 1'b1, 100, -1);
        n_checks++;
        if (wait_cycles != 10) begin
            n_fail++; $display("FAIL read_latency: cpu_wait high %0d cycles, required 10", wait_cycles);
        end
        n_checks++;
        if (cpu_dout !== 8'h3C) begin
            n_fail++; $display("FAIL read_dout: got %h, required 3c", cpu_dout);
        end
        for (int i = 0; i < 3; i++) begin
            sd_dout = 8'(8'h50 + i);
            cpu_access(1'b1, 23'(23'h000200 + i), 8'(8'hC0 + i), 1'b1, 100, -1);
            n_checks++;
            if (cpu_dout !== 8'h3C) begin
                n_fail++; $display("FAIL read_hold: after write %0d got %h, required 3c", i, cpu_dout);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL read_missing: %0d requests not seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_ack_window();
        ctl_en  = 1'b0;
        sd_dout = 8'h5A;
        cpu_access(1'b0, 23'h7FFFFF, 8'h0F, 1'b1, 100, -1);
        n_checks++;
        if (wait_cycles != 6) begin
            n_fail++; $display("FAIL ackwin_latency: cpu_wait high %0d cycles, required 6", wait_cycles);
        end
        n_checks++;
        if (cpu_dout !== 8'h5A) begin
            n_fail++; $display("FAIL ackwin_dout: got %h, required 5a", cpu_dout);
        end
        ctl_en = 1'b1;
    endtask

    task automatic test_contention();
        ctl_hold     = 3;
        sd_busy      = 1'b1;
        ctl_left     = 5;
        bad_pulses   = 0;
        addr_changes = 0;
        cpu_access(1'b1, 23'h055AA5, 8'h69, 1'b1, 100, 2);
        repeat (3) step();
        n_checks++;
        if (bad_pulses != 0) begin
            n_fail++; $display("FAIL contention_busy: %0d pulses while busy, required 0", bad_pulses);
        end
        n_checks++;
        if (addr_changes != 0) begin
            n_fail++; $display("FAIL contention_addr: sd_addr changed %0d times, required 0", addr_changes);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL contention_missing: %0d requests not seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        ctl_hold = 2;
        sd_dout  = 8'h00;
        cpu_access(1'b1, 23'h000321, 8'h77, 1'b1, 100, -1);
        sd_dout  = 8'h77;
        cpu_access(1'b0, 23'h000321, 8'h00, 1'b1, 100, -1);
        n_checks++;
        if (wait_cycles != 6) begin
            n_fail++; $display("FAIL b2b_latency: cpu_wait high %0d cycles, required 6", wait_cycles);
        end
        n_checks++;
        if (cpu_dout !== 8'h77) begin
            n_fail++; $display("FAIL b2b_dout: got %h, required 77", cpu_dout);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_missing: %0d requests not seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        ctl_hold = 5000;
        sd_dout  = 8'h12;
        cpu_access(1'b0, 23'h000777, 8'h00, 1'b1, 1100, -1);
        repeat (3) step();
        n_checks++;
        if (err_pulses != 1) begin
            n_fail++; $display("FAIL timeout_pulse: err_timeout high %0d cycles, required 1", err_pulses);
        end
        n_checks++;
        if (cpu_dout !== 8'hFF) begin
            n_fail++; $display("FAIL timeout_dout: got %h, required ff", cpu_dout);
        end
        n_checks++;
        if ((wait_cycles < 1024) || (wait_cycles > 1032)) begin
            n_fail++; $display("FAIL timeout_length: cpu_wait high %0d cycles, required 1024..1032", wait_cycles);
        end
        ctl_left    = 0;
        ctl_pending = 1'b0;
        sd_busy     = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        ctl_hold = 50;
        sd_dout  = 8'h44;
        exp_q.push_back({1'b0, 2'b00, 23'h000456, 8'h00});
        fast_clk = 1'b1; cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000456; cpu_din = 8'h00;
        step();
        fast_clk = 1'b0; cpu_ce = 1'b0;
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cpu_wait, sd_rd, sd_wr} !== 3'b000) begin
            n_fail++; $display("FAIL resetmid_ctrl: got wait=%b rd=%b wr=%b, required 000", cpu_wait, sd_rd, sd_wr);
        end
        n_checks++;
        if (cpu_dout !== 8'h00) begin
            n_fail++; $display("FAIL resetmid_dout: got %h, required 00", cpu_dout);
        end
        ctl_left = 0; ctl_pending = 1'b0; sd_busy = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL resetmid_missing: %0d requests not seen, required 0", exp_q.size());
        end
        ctl_hold = 2;
        sd_dout  = 8'hC3;
        cpu_access(1'b0, 23'h000456, 8'h00, 1'b1, 100, -1);
        n_checks++;
        if ((cpu_dout !== 8'hC3) || (wait_cycles != 6)) begin
            n_fail++; $display("FAIL resetmid_after: got dout=%h wait=%0d, required dout=c3 wait=6", cpu_dout, wait_cycles);
        end
    endtask

`ifdef FASTRAM_READ_CACHE_EN
    task automatic test_cache();
        ctl_hold = 2;
        sd_dout  = 8'h11;
        cpu_access(1'b0, 23'h000100, 8'h00, 1'b1, 100, -1);
        n_checks++;
        if (cpu_dout !== 8'h11) begin
            n_fail++; $display("FAIL cache_miss: got %h, required 11", cpu_dout);
        end
        sd_dout = 8'hEE;
        cpu_access(1'b0, 23'h000100, 8'h00, 1'b0, 100, -1);
        repeat (3) step();
        n_checks++;
        if ((cpu_dout !== 8'h11) || (wait_cycles != 0)) begin
            n_fail++; $display("FAIL cache_hit: got dout=%h wait=%0d, required dout=11 wait=0", cpu_dout, wait_cycles);
        end
        cpu_access(1'b1, 23'h000100, 8'h22, 1'b1, 100, -1);
        cpu_access(1'b0, 23'h000100, 8'h00, 1'b0, 100, -1);
        repeat (3) step();
        n_checks++;
        if ((cpu_dout !== 8'h22) || (wait_cycles != 0)) begin
            n_fail++; $display("FAIL cache_wt: got dout=%h wait=%0d, required dout=22 wait=0", cpu_dout, wait_cycles);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL cache_missing: %0d requests not seen, required 0", exp_q.size());
        end
    endtask
`else
    task automatic test_no_cache();
        ctl_hold = 2;
        sd_dout  = 8'h11;
        cpu_access(1'b0, 23'h000100, 8'h00, 1'b1, 100, -1);
        sd_dout  = 8'hEE;
        cpu_access(1'b0, 23'h000100, 8'h00, 1'b1, 100, -1);
        n_checks++;
        if ((cpu_dout !== 8'hEE) || (wait_cycles != 6)) begin
            n_fail++; $display("FAIL nocache_reread: got dout=%h wait=%0d, required dout=ee wait=6", cpu_dout, wait_cycles);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL nocache_missing: %0d requests not seen, required 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0; fast_clk = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0;
        cpu_addr = 23'd0; cpu_din = 8'h00; sd_dout = 8'h00; sd_busy = 1'b0;
        ctl_en = 1'b1; ctl_pending = 1'b0; ctl_left = 0; ctl_hold = 1;
        wait_cycles = 0; err_pulses = 0; bad_pulses = 0; addr_changes = 0;
        prev_wait = 1'b0; prev_addr = 25'd0;
        test_reset();
        test_write();
        test_read();
        test_ack_window();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
`ifdef FASTRAM_READ_CACHE_EN
        test_cache();
`else
        test_no_cache();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
